// File: rtl/sm_input_conditioner.sv
// ---------------------------------------------------------------------------
// sm_input_conditioner
//
// Cleans up raw asynchronous board inputs (GPIO, KEY, SW) before they reach
// the processor core. Each bit goes through three steps:
//   1. A SYNC_STAGES-deep flip-flop chain brings the bit into the clk domain.
//   2. A debounce counter accepts a new level only after it has held for
//      DEBOUNCE consecutive cycles.
//   3. Registered rise/fall pulses, one cycle wide, mark each accepted change.
// Every output is registered, so in_raw has no combinational path to any
// output.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   rst         synchronous reset, active-high
//   in_raw      [WIDTH] asynchronous raw inputs from the pins
//   in_clean    [WIDTH] debounced level per bit
//   in_rise     [WIDTH] one-cycle pulse when in_clean[i] goes 0->1
//   in_fall     [WIDTH] one-cycle pulse when in_clean[i] goes 1->0
//   in_changed  OR of all rise/fall pulses, registered together with them
// ---------------------------------------------------------------------------
module sm_input_conditioner #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               DEBOUNCE    = 50000,
   parameter int               CNT_W       = 16,
   parameter logic [WIDTH-1:0] INIT        = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] in_clean,
   output logic [WIDTH-1:0] in_rise,
   output logic [WIDTH-1:0] in_fall,
   output logic             in_changed
);

   // Reject parameter sets the counter cannot represent.
   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("sm_input_conditioner: SYNC_STAGES must be at least 2");
      end
      if (DEBOUNCE < 1) begin : g_bad_deb
         $error("sm_input_conditioner: DEBOUNCE must be at least 1");
      end
      if (CNT_W < 31 && DEBOUNCE >= (1 << CNT_W)) begin : g_bad_cnt
         $error("sm_input_conditioner: CNT_W too narrow for DEBOUNCE");
      end
   endgenerate

   // Counter value on the cycle a mismatch is accepted.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0][CNT_W-1:0]       r_cnt;
   logic [WIDTH-1:0]                  r_clean;
   logic [WIDTH-1:0]                  r_rise;
   logic [WIDTH-1:0]                  r_fall;
   logic                              r_changed;

   logic [WIDTH-1:0]                  w_s;
   logic [WIDTH-1:0][CNT_W-1:0]       w_cnt_nxt;
   logic [WIDTH-1:0]                  w_clean_nxt;
   logic [WIDTH-1:0]                  w_rise_nxt;
   logic [WIDTH-1:0]                  w_fall_nxt;

   // --- synchronizer stage: in_raw -> r_sync[0] ... r_sync[SYNC_STAGES-1]
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{INIT}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_raw};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // --- debounce decision: per-bit counter against the accepted level
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = r_clean;
      w_rise_nxt  = '0;
      w_fall_nxt  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_s[i] == r_clean[i]) begin
            // Agreement (or a glitch that ended) discards any partial count.
            w_cnt_nxt[i] = '0;
         end else if (r_cnt[i] == LP_LAST) begin
            // Clearing here, not wrapping, keeps the counter bounded.
            w_cnt_nxt[i]   = '0;
            w_clean_nxt[i] = w_s[i];
            w_rise_nxt[i]  = w_s[i];
            w_fall_nxt[i]  = ~w_s[i];
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end
      end
   end

   // --- output stage: accepted level, pulses and summary flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_clean   <= INIT;
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_clean   <= w_clean_nxt;
         r_rise    <= w_rise_nxt;
         r_fall    <= w_fall_nxt;
         r_changed <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign in_clean   = r_clean;
   assign in_rise    = r_rise;
   assign in_fall    = r_fall;
   assign in_changed = r_changed;

endmodule

// File: tb/tb_sm_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sm_input_conditioner
//
// Directed bench for sm_input_conditioner with WIDTH=4, SYNC_STAGES=2 and
// DEBOUNCE=4. One instance resets to 4'b0000. A second instance resets to
// 4'b1111 and has its input tied high. Loop index k counts edges from E,
// the first edge that samples a new in_raw value. A level held from E is
// accepted at k = SYNC_STAGES-1+DEBOUNCE = 5.
// ---------------------------------------------------------------------------
module tb_sm_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_a, clean_a, rise_a, fall_a;
   logic       chg_a;
   logic [3:0] raw_b, clean_b, rise_b, fall_b;
   logic       chg_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sm_input_conditioner #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(16), .INIT(4'b0000)
   ) dut (
      .clk(clk), .rst(rst), .in_raw(raw_a), .in_clean(clean_a),
      .in_rise(rise_a), .in_fall(fall_a), .in_changed(chg_a)
   );

   sm_input_conditioner #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(16), .INIT(4'b1111)
   ) dut_b (
      .clk(clk), .rst(rst), .in_raw(raw_b), .in_clean(clean_b),
      .in_rise(rise_b), .in_fall(fall_b), .in_changed(chg_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [3:0] c,
                          input logic [3:0] r, input logic [3:0] f);
      check_val({tag, "_clean"}, 32'(clean_a), 32'(c));
      check_val({tag, "_rise"},  32'(rise_a),  32'(r));
      check_val({tag, "_fall"},  32'(fall_a),  32'(f));
      check_val({tag, "_chg"},   32'(chg_a),   32'((r | f) != 4'b0000));
   endtask

   initial begin
      rst   = 1'b1;
      raw_a = 4'b0000;
      raw_b = 4'b1111;
      tick();
      tick();
      check_a("reset", 4'b0000, 4'b0000, 4'b0000);
      check_val("reset_b_clean", 32'(clean_b), 32'h0000000f);
      rst = 1'b0;
      tick();
      check_a("idle", 4'b0000, 4'b0000, 4'b0000);

      // Clean rising edge on bit 0.
      raw_a = 4'b0001;
      for (int k = 0; k <= 8; k++) begin
         tick();
         check_a("clean_edge", (k >= 5) ? 4'b0001 : 4'b0000,
                 (k == 5) ? 4'b0001 : 4'b0000, 4'b0000);
      end

      // Bit 1 high for 3 samples only: one short of acceptance.
      raw_a = 4'b0011;
      for (int k = 0; k <= 10; k++) begin
         tick();
         if (k == 2) raw_a = 4'b0001;
         check_a("glitch", 4'b0001, 4'b0000, 4'b0000);
      end
      check_val("glitch_cnt1", 32'(dut.r_cnt[1]), 32'd0);

      // Bit 2 bounces 1,0, then holds 1 from E+2 -> accepted at k=7.
      for (int k = 0; k <= 11; k++) begin
         raw_a = {1'b0, (k == 1) ? 1'b0 : 1'b1, 2'b01};
         tick();
         check_a("bounce", (k >= 7) ? 4'b0101 : 4'b0001,
                 (k == 7) ? 4'b0100 : 4'b0000, 4'b0000);
      end

      // Bits 1 and 3 rise together.
      raw_a = 4'b1111;
      for (int k = 0; k <= 7; k++) begin
         tick();
         check_a("multi_rise", (k >= 5) ? 4'b1111 : 4'b0101,
                 (k == 5) ? 4'b1010 : 4'b0000, 4'b0000);
      end

      // All four bits fall together.
      raw_a = 4'b0000;
      for (int k = 0; k <= 7; k++) begin
         tick();
         check_a("multi_fall", (k >= 5) ? 4'b0000 : 4'b1111,
                 4'b0000, (k == 5) ? 4'b1111 : 4'b0000);
      end

      // Reset at E+4, after two counted cycles; restart accepts at k=10.
      raw_a = 4'b1000;
      for (int k = 0; k <= 12; k++) begin
         rst = (k == 4);
         tick();
         if (k == 3) check_val("rst_mid_cnt2", 32'(dut.r_cnt[3]), 32'd2);
         if (k == 4) check_val("rst_mid_cnt0", 32'(dut.r_cnt[3]), 32'd0);
         check_a("rst_mid", (k >= 10) ? 4'b1000 : 4'b0000,
                 (k == 10) ? 4'b1000 : 4'b0000, 4'b0000);
      end
      rst = 1'b0;

      // INIT=1111 with input high across reset: no pulses at all.
      rst = 1'b1;
      tick();
      check_val("init_clean_rst", 32'(clean_b), 32'h0000000f);
      check_val("init_pulse_rst", 32'(rise_b | fall_b), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         check_val("init_clean", 32'(clean_b), 32'h0000000f);
         check_val("init_pulse", 32'(rise_b | fall_b), 32'd0);
         check_val("init_chg", 32'(chg_b), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sm_input_conditioner.md
Name: sm_input_conditioner

Overview:
- Conditions raw asynchronous board inputs (GPIO, KEY, SW) before they reach the processor core's external-input and clock-enable pins.
- Per bit: synchronizes to the system clock, debounces, and emits single-cycle rise/fall pulses.
- The core sees only clean, glitch-free levels. The step pulse drives single-cycle stepping of the clock enable.

Parameters:
- WIDTH, 8, number of independent input bits
- SYNC_STAGES, 2, flip-flop stages in each synchronizer chain; minimum 2
- DEBOUNCE, 50000, consecutive cycles a new synchronized level must persist before acceptance (1 ms at 50 MHz); minimum 1
- CNT_W, 16, per-bit debounce counter width; requires 2^CNT_W > DEBOUNCE
- INIT, {WIDTH{1'b0}}, reset value of the synchronizers and of in_clean (all-ones for active-low keys)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_raw  input  WIDTH  asynchronous raw inputs from pins
- in_clean  output  WIDTH  debounced level per bit
- in_rise  output  WIDTH  one-cycle pulse when in_clean[i] goes 0->1
- in_fall  output  WIDTH  one-cycle pulse when in_clean[i] goes 1->0
- in_changed  output  1  OR of in_rise | in_fall, registered together with them

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Everything else is registered on the rising edge of clk. No combinational path from in_raw to any output.
- Reset values, applied when rst=1 at a clk edge:
  - all synchronizer stages = INIT
  - in_clean = INIT
  - all counters = 0
  - in_rise = in_fall = 0, in_changed = 0
- Synchronizer: in_raw[i] shifts through SYNC_STAGES flops. s[i] is the last stage.
- Debounce, per bit, evaluated each cycle:
  - If s[i] == in_clean[i]: cnt[i] <= 0. No change.
  - If s[i] != in_clean[i] and cnt[i] < DEBOUNCE-1: cnt[i] <= cnt[i]+1.
  - If s[i] != in_clean[i] and cnt[i] == DEBOUNCE-1: in_clean[i] <= s[i] and cnt[i] <= 0. The matching pulse is set in the same edge: in_rise[i] if s[i]=1, in_fall[i] if s[i]=0.
- Pulses:
  - in_rise/in_fall are high for exactly one cycle, otherwise 0.
  - A bit can never pulse on consecutive cycles unless DEBOUNCE=1.
  - in_changed = |(next rise | next fall), registered with them.
- Latency: in_raw changes and is then held stable from edge E onward, where edge E is the first stage's sample. in_clean and the pulse update at edge E + SYNC_STAGES - 1 + DEBOUNCE.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE consecutive cycles at s[i] resets the counter and causes no change. A bounce restarts the full count.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses on each.
- DEBOUNCE=1: a mismatch is accepted on the first cycle it is seen at s[i].
- Reset mid-count:
  - pending counts are discarded, in_clean returns to INIT, pulses are cleared
  - no pulse is generated for the reset-induced level change
- The counter never wraps: it saturates logically by clearing at acceptance. CNT_W is checked against DEBOUNCE by an elaboration-time assertion.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=4, INIT=0 unless stated):
- Clean edge: release rst, then hold in_raw=4'b0001 from edge E -> in_clean=4'b0001 and in_rise=4'b0001 (one cycle) and in_changed=1 at edge E+5. All other cycles have zero pulses.
- Glitch: in_raw[1] high for 3 cycles then low -> in_clean[1] stays 0, no pulses, cnt[1] back to 0.
- Bounce: in_raw[2] = 1,0,1,1,1,1... -> acceptance delayed to 4 stable cycles after the last 0 reaches s[2]. Exactly one in_rise[2] pulse.
- Fall and multi-bit: in_clean=4'b1111; drive in_raw=4'b0000 -> in_fall=4'b1111 in a single cycle, in_clean=0 the same edge.
- Reset mid-count: raw bit 3 goes high, assert rst for 1 cycle after 2 counted cycles -> in_clean=0, no pulse. Count restarts from 0 after rst deasserts, accepting 4 cycles later.
- INIT=4'b1111 with in_raw=4'b1111 across reset -> in_clean=4'b1111 immediately after reset, zero pulses for 100 cycles.
